// File: rtl/tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tick_period_monitor
//
// Measures the spacing of a single-cycle tick strobe (typically a clock
// divider / enable output) and reports whether it runs at the nominal period.
// The first tick after reset or timeout only arms the monitor. Every later
// tick publishes the measured period. LOCK_COUNT consecutive on-period ticks
// declare lock. Once locked, a wrong period or a missing tick is flagged as a
// mismatch. A long tick-free stretch drops the monitor back to idle.
//
// Parameters
//   EXPECTED_PERIOD  nominal clk cycles between ticks (1..MAX_PERIOD-1)
//   LOCK_COUNT       consecutive matching periods needed to lock (1..15)
//   MAX_PERIOD       tick-free count treated as timeout; sets counter width W
//
// Ports
//   clk           sole clock, all logic on posedge
//   rst           synchronous, active-high reset
//   tick_in       single-cycle tick strobe
//   period_out    last measured period (W bits)
//   period_valid  one-cycle pulse, period_out updated this cycle
//   locked        level, tick stream matches EXPECTED_PERIOD
//   mismatch      one-cycle pulse, wrong period or missed tick while locked
//   timeout       one-cycle pulse, tick stream lost, back to idle
//   err_count     number of mismatch pulses, saturating at 255
// -----------------------------------------------------------------------------
module tick_period_monitor #(
  parameter int unsigned EXPECTED_PERIOD = 4,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned MAX_PERIOD      = 1023,
  localparam int unsigned W              = $clog2(MAX_PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_in,
  output logic [W-1:0] period_out,
  output logic         period_valid,
  output logic         locked,
  output logic         mismatch,
  output logic         timeout,
  output logic [7:0]   err_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [W-1:0] EXP_CNT = W'(EXPECTED_PERIOD);
  localparam logic [W-1:0] MAX_CNT = W'(MAX_PERIOD);
  // The timeout decision is taken one count early so the pulse appears in
  // the cycle where the counter reaches MAX_PERIOD.
  localparam logic [W-1:0] TO_CNT  = W'(MAX_PERIOD - 1);
  localparam logic [3:0]   LOCK_MC = 4'(LOCK_COUNT);

  // Saturating increment of the tick-spacing counter (holds at MAX_PERIOD).
  function automatic logic [W-1:0] cnt_sat_inc(input logic [W-1:0] c);
    if (c == MAX_CNT) begin
      return c;
    end
    return c + W'(1);
  endfunction

  // Saturating increment of the 8-bit error counter.
  function automatic logic [7:0] err_sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end
    return v + 8'd1;
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [3:0]   mc_q, mc_d;
  logic [W-1:0] period_out_q, period_out_d;
  logic         period_valid_q, period_valid_d;
  logic         locked_q, locked_d;
  logic         mismatch_q, mismatch_d;
  logic         timeout_q, timeout_d;
  logic [7:0]   err_count_q, err_count_d;

  // Event decode, all from registered state plus the sampled tick.
  logic       period_match;
  logic       missed_tick;
  logic       lost_stream;
  logic [3:0] mc_inc;
  logic       lock_hit;

  always_comb begin
    // cnt_q on a tick cycle is exactly the spacing since the previous tick.
    period_match = (cnt_q == EXP_CNT);
    // While locked, reaching the nominal count without a tick means the
    // expected tick did not arrive.
    missed_tick  = !tick_in && (state_q == ST_LOCKED) && (cnt_q == EXP_CNT);
    // A missed tick in the same cycle wins, so only one pulse is emitted.
    lost_stream  = !tick_in && (state_q != ST_IDLE) && (cnt_q == TO_CNT) &&
                   !missed_tick;
    mc_inc       = mc_q + 4'd1;
    lock_hit     = (mc_inc == LOCK_MC);
  end

  // Tick-spacing counter, restarts at 1 so a tick P cycles later reads P.
  always_comb begin
    cnt_d = tick_in ? W'(1) : cnt_sat_inc(cnt_q);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and match counter.
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tick_in) begin
          state_d = ST_ACQUIRE;
          mc_d    = 4'd0;
        end
      end
      ST_ACQUIRE: begin
        if (tick_in) begin
          if (period_match) begin
            mc_d = mc_inc;
            if (lock_hit) begin
              state_d = ST_LOCKED;
            end
          end else begin
            mc_d = 4'd0;
          end
        end else if (lost_stream) begin
          state_d = ST_IDLE;
          mc_d    = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (tick_in) begin
          if (!period_match) begin
            state_d = ST_ACQUIRE;
            mc_d    = 4'd0;
          end
        end else if (missed_tick) begin
          state_d = ST_ACQUIRE;
          mc_d    = 4'd0;
        end else if (lost_stream) begin
          state_d = ST_IDLE;
          mc_d    = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mc_d    = 4'd0;
      end
    endcase
  end

  // FSM outputs, computed one cycle ahead and registered below.
  always_comb begin
    period_out_d   = period_out_q;
    period_valid_d = 1'b0;
    mismatch_d     = 1'b0;
    timeout_d      = 1'b0;
    locked_d       = (state_d == ST_LOCKED);

    // Ticks outside idle carry a measurement; the arming tick does not.
    if (tick_in && (state_q != ST_IDLE)) begin
      period_out_d   = cnt_q;
      period_valid_d = 1'b1;
    end

    if ((state_q == ST_LOCKED) && tick_in && !period_match) begin
      mismatch_d = 1'b1;
    end
    if (missed_tick) begin
      mismatch_d = 1'b1;
    end

    if (lost_stream) begin
      timeout_d = 1'b1;
    end

    err_count_d = mismatch_d ? err_sat_inc(err_count_q) : err_count_q;
  end

  // ---- register stage: counter, match count and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      mc_q           <= 4'd0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      mismatch_q     <= 1'b0;
      timeout_q      <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      cnt_q          <= cnt_d;
      mc_q           <= mc_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      mismatch_q     <= mismatch_d;
      timeout_q      <= timeout_d;
      err_count_q    <= err_count_d;
    end
  end

  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign mismatch     = mismatch_q;
  assign timeout      = timeout_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for tick_period_monitor (EXPECTED_PERIOD=4, LOCK_COUNT=3,
// MAX_PERIOD=15). Directed scenarios check against fixed expected values;
// the random scenario checks every output every cycle against a timestamp
// based reference model.
// -----------------------------------------------------------------------------
module tb_tick_period_monitor;

  localparam int EXP  = 4;
  localparam int LOCK = 3;
  localparam int MAXP = 15;
  localparam int W    = $clog2(MAXP + 1);

  logic         clk;
  logic         rst;
  logic         tick_in;
  logic [W-1:0] period_out;
  logic         period_valid;
  logic         locked;
  logic         mismatch;
  logic         timeout;
  logic [7:0]   err_count;

  int n_checks;
  int n_fail;

  tick_period_monitor #(
    .EXPECTED_PERIOD(EXP),
    .LOCK_COUNT     (LOCK),
    .MAX_PERIOD     (MAXP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .locked      (locked),
    .mismatch    (mismatch),
    .timeout     (timeout),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembers the time of the last tick and derives the
  // period from elapsed time, saturated at MAXP.
  int         gcyc;
  bit         m_armed;
  bit         m_locked;
  int         m_matches;
  int         m_last;
  logic [W-1:0] m_pout;
  bit         m_pv;
  bit         m_mm;
  bit         m_to;
  logic [7:0] m_err;

  task automatic model_step(input bit t, input bit r);
    int el;
    m_pv = 0;
    m_mm = 0;
    m_to = 0;
    el = gcyc - m_last;
    if (el > MAXP) el = MAXP;
    if (r) begin
      m_armed   = 0;
      m_locked  = 0;
      m_matches = 0;
      m_pout    = '0;
      m_err     = 8'd0;
    end else if (t) begin
      if (!m_armed) begin
        m_armed   = 1;
        m_matches = 0;
      end else begin
        m_pv   = 1;
        m_pout = W'(el);
        if (m_locked) begin
          if (el != EXP) begin
            m_locked  = 0;
            m_matches = 0;
            m_mm      = 1;
          end
        end else if (el == EXP) begin
          m_matches++;
          if (m_matches == LOCK) m_locked = 1;
        end else begin
          m_matches = 0;
        end
      end
      m_last = gcyc;
    end else if (m_armed) begin
      if (m_locked && el == EXP) begin
        m_locked  = 0;
        m_matches = 0;
        m_mm      = 1;
      end else if (el == MAXP - 1) begin
        m_armed  = 0;
        m_locked = 0;
        m_to     = 1;
      end
    end
    if (m_mm && m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  // One clock cycle: drive inputs, let the edge sample them, settle, advance
  // the model with the same inputs.
  task automatic cyc(input bit t, input bit r);
    tick_in = t;
    rst     = r;
    @(posedge clk);
    #1;
    model_step(t, r);
    gcyc++;
  endtask

  task automatic do_reset();
    cyc(0, 1);
    cyc(0, 1);
  endtask

  // (n-1) quiet cycles followed by a tick: tick spacing n.
  task automatic gap(input int n);
    for (int i = 1; i < n; i++) cyc(0, 0);
    cyc(1, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (period_out !== '0) begin n_fail++; $display("FAIL reset_period_out got %0d want 0", period_out); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_period_valid got %b want 0", period_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
  endtask

  // Ticks at 2,6,10,14: valid at 7,11,15 with period 4, lock at 15.
  task automatic test_lock();
    int oc;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      cyc(c == 2 || c == 6 || c == 10 || c == 14, 0);
      oc = c + 1;
      n_checks++;
      if (period_valid !== (oc == 7 || oc == 11 || oc == 15)) begin
        n_fail++; $display("FAIL lock_period_valid cycle %0d got %b", oc, period_valid);
      end
      if (oc == 7 || oc == 11 || oc == 15) begin
        n_checks++;
        if (period_out !== 4'd4) begin n_fail++; $display("FAIL lock_period_out cycle %0d got %0d want 4", oc, period_out); end
      end
      n_checks++;
      if (locked !== (oc >= 15)) begin n_fail++; $display("FAIL lock_locked cycle %0d got %b want %b", oc, locked, oc >= 15); end
      n_checks++;
      if (mismatch !== 1'b0) begin n_fail++; $display("FAIL lock_mismatch cycle %0d got %b want 0", oc, mismatch); end
    end
  endtask

  // Locked, then a tick 3 cycles after the last one.
  task automatic test_period_dev();
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      cyc(c == 2 || c == 6 || c == 10 || c == 14 || c == 17, 0);
    end
    n_checks++; if (period_out !== 4'd3) begin n_fail++; $display("FAIL dev_period_out got %0d want 3", period_out); end
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("FAIL dev_period_valid got %b want 1", period_valid); end
    n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL dev_mismatch got %b want 1", mismatch); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL dev_locked got %b want 0", locked); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL dev_err_count got %0d want 1", err_count); end
  endtask

  // Locked, ticks stop: mismatch at 19, timeout at 29, next tick only arms.
  task automatic test_missed_timeout();
    int oc;
    int n_mm;
    n_mm = 0;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      cyc(c == 2 || c == 6 || c == 10 || c == 14, 0);
      oc = c + 1;
      if (oc >= 16) begin
        if (mismatch) n_mm++;
        n_checks++;
        if (timeout !== (oc == 29)) begin n_fail++; $display("FAIL miss_timeout cycle %0d got %b", oc, timeout); end
        n_checks++;
        if (locked !== 1'b0 && oc >= 19) begin n_fail++; $display("FAIL miss_locked cycle %0d got %b want 0", oc, locked); end
      end
      if (oc == 19) begin
        n_checks++;
        if (mismatch !== 1'b1) begin n_fail++; $display("FAIL miss_mismatch got %b want 1", mismatch); end
      end
    end
    n_checks++;
    if (n_mm != 1) begin n_fail++; $display("FAIL miss_pulse_count got %0d want 1", n_mm); end
    cyc(1, 0);
    n_checks++;
    if (period_valid !== 1'b0) begin n_fail++; $display("FAIL idle_arm_period_valid got %b want 0", period_valid); end
  endtask

  // Ticks at 3,4,5 from idle: valid at 5 and 6 with period 1.
  task automatic test_back_to_back();
    int oc;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      cyc(c >= 3 && c <= 5, 0);
      oc = c + 1;
      n_checks++;
      if (period_valid !== (oc == 5 || oc == 6)) begin n_fail++; $display("FAIL b2b_period_valid cycle %0d got %b", oc, period_valid); end
      if (oc == 5 || oc == 6) begin
        n_checks++;
        if (period_out !== 4'd1) begin n_fail++; $display("FAIL b2b_period_out cycle %0d got %0d want 1", oc, period_out); end
      end
      n_checks++;
      if (locked !== 1'b0) begin n_fail++; $display("FAIL b2b_locked cycle %0d got %b want 0", oc, locked); end
    end
  endtask

  // Reset mid-acquire discards history; fresh lock needs a new arming tick.
  task automatic test_rst_mid();
    int oc;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      cyc(c == 2 || c == 6 || c == 12 || c == 16 || c == 20 || c == 24, c == 9);
      oc = c + 1;
      if (oc == 10) begin
        n_checks++;
        if ({period_out, period_valid, locked, mismatch, timeout, err_count} !== '0) begin
          n_fail++; $display("FAIL rstmid_outputs po=%0d pv=%b lk=%b mm=%b to=%b ec=%0d want all 0",
                             period_out, period_valid, locked, mismatch, timeout, err_count);
        end
      end
      if (oc >= 10) begin
        n_checks++;
        if (locked !== (oc >= 25)) begin n_fail++; $display("FAIL rstmid_locked cycle %0d got %b want %b", oc, locked, oc >= 25); end
      end
    end
  endtask

  // 300 lock/mismatch rounds; err_count must stop at 255.
  task automatic test_saturate();
    int k;
    do_reset();
    cyc(1, 0);
    gap(4); gap(4); gap(4);
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_initial_lock got %b want 1", locked); end
    for (k = 1; k <= 300; k++) begin
      gap(3);
      n_checks++;
      if (mismatch !== 1'b1) begin n_fail++; $display("FAIL sat_mismatch round %0d got %b want 1", k, mismatch); end
      n_checks++;
      if (err_count !== 8'((k > 255) ? 255 : k)) begin
        n_fail++; $display("FAIL sat_err_count round %0d got %0d want %0d", k, err_count, (k > 255) ? 255 : k);
      end
      gap(4); gap(4); gap(4);
      n_checks++;
      if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_relock round %0d got %b want 1", k, locked); end
    end
    n_checks++;
    if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_final got %0d want 255", err_count); end
  endtask

  // Random tick spacing and occasional reset, full compare every cycle.
  task automatic test_random();
    int wait_left;
    bit t;
    bit r;
    do_reset();
    wait_left = 3;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 599) == 0);
      t = (wait_left == 0);
      if (t) begin
        if ($urandom_range(0, 9) < 6) wait_left = EXP - 1;
        else wait_left = $urandom_range(0, 19);
      end else begin
        wait_left--;
      end
      cyc(t, r);
      n_checks++;
      if (period_out !== m_pout) begin n_fail++; $display("FAIL rnd_period_out cyc %0d got %0d want %0d", gcyc, period_out, m_pout); end
      n_checks++;
      if (period_valid !== m_pv) begin n_fail++; $display("FAIL rnd_period_valid cyc %0d got %b want %b", gcyc, period_valid, m_pv); end
      n_checks++;
      if (locked !== m_locked) begin n_fail++; $display("FAIL rnd_locked cyc %0d got %b want %b", gcyc, locked, m_locked); end
      n_checks++;
      if (mismatch !== m_mm) begin n_fail++; $display("FAIL rnd_mismatch cyc %0d got %b want %b", gcyc, mismatch, m_mm); end
      n_checks++;
      if (timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout cyc %0d got %b want %b", gcyc, timeout, m_to); end
      n_checks++;
      if (err_count !== m_err) begin n_fail++; $display("FAIL rnd_err_count cyc %0d got %0d want %0d", gcyc, err_count, m_err); end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    gcyc      = 0;
    m_armed   = 0;
    m_locked  = 0;
    m_matches = 0;
    m_last    = 0;
    m_pout    = '0;
    m_pv      = 0;
    m_mm      = 0;
    m_to      = 0;
    m_err     = 8'd0;
    tick_in   = 1'b0;
    rst       = 1'b1;

    test_reset();
    test_lock();
    test_period_dev();
    test_missed_timeout();
    test_back_to_back();
    test_rst_mid();
    test_saturate();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
